univ_shift_reg_param: RTL and testbench
=======================================

# univ_shift_reg_param

Parametrised universal shift register, the next generation of the 4-bit universal shift register. It adds configurable width, multi-bit barrel shifts, rotates, arithmetic shift right and a self-timed serialiser mode with busy/done status. It is used as a general datapath register and as the parallel-to-serial front end for the serial-link blocks.

## Interface
- WIDTH, 8, register width; power of two, 4..64
- AW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
- en  in  1  operation enable; 0 = hold / pause
- s  in  3  mode select (see Operation)
- amt  in  AW  shift/rotate amount, 0..WIDTH-1
- din  in  WIDTH  parallel load data
- sin  in  1  serial fill bit, replicated into every vacated position
- q  out  WIDTH  register contents
- sout_r  out  1  q[0] (LSB serial out)
- sout_l  out  1  q[WIDTH-1] (MSB serial out)
- busy  out  1  serialiser active
- done  out  1  final serialiser bit present on sout_r

## Operation
- Modes of s, applied at the clk edge when en=1 and busy=0:
  - 000 hold
  - 001 logical shift right by amt; top amt bits = sin
  - 010 logical shift left by amt; bottom amt bits = sin
  - 011 parallel load q <= din
  - 100 rotate right by amt
  - 101 rotate left by amt
  - 110 arithmetic shift right by amt; top amt bits = old q[WIDTH-1]; sin ignored
  - 111 serialise start
- amt=0 in any shift/rotate mode leaves q unchanged.
- en=0 with busy=0: q holds, all inputs ignored.
- Serialiser state: busy flag plus down-counter cnt (AW bits).
  - Start edge: q <= din, busy <= 1, cnt <= WIDTH-1.
  - Each later edge with en=1 and cnt≠0: q <= {sin, q[WIDTH-1:1]}, cnt <= cnt-1.
  - Edge with en=1 and cnt=0 (the done cycle): busy <= 0 and q holds, unless s=111. In that case a back-to-back start is accepted: q <= din, cnt <= WIDTH-1, busy stays 1.
  - en=0 while busy: q and cnt frozen (pause); done stays as decoded.
  - While busy, s/amt/din are ignored except the back-to-back start in the done cycle.
- done = busy & (cnt==0), decoded combinationally from registers.
- sout_r / sout_l are taken directly from q, with no extra register.

## Timing
- Reset (rst=0 at an edge): q=0, busy=0, cnt=0. Hence sout_r=0, sout_l=0, done=0. Reset overrides en and s and aborts a serialisation mid-stream.
- All non-serialiser modes have 1-cycle latency: the result is on q immediately after the edge.
- Serialiser with no pauses:
  - busy is high for exactly WIDTH cycles after the start edge.
  - sout_r presents din[0], din[1], … din[WIDTH-1], one bit per cycle.
  - done is high only in the cycle presenting din[WIDTH-1].
- Back-to-back starts yield a gapless stream of WIDTH·N bits. done pulses once per word.
- Each pause cycle (en=0) stretches busy and delays subsequent bits by one cycle.

## Structure
- Package usr_pkg holds localparams for the eight mode codes (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD, USR_ROR, USR_ROL, USR_ASR, USR_SER).
- Sub-module usr_barrel is a purely combinational WIDTH-bit barrel shifter: inputs data, amt, dir, rotate, arith, fill; output result. It uses log2(WIDTH) mux stages.
- The top level holds q, busy, cnt, mode decode and the serialiser control.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive rst=0 for 2 edges with s=011, din=0xFF, en=1 -> q=0x00, busy=0, done=0. Then assert rst=0 during a serialisation -> busy=0 and q=0x00 on the next edge.
- Shifts: load 0x96, then s=001, amt=3, sin=1 -> 0xF2. Reload 0x96, then s=010, amt=2, sin=0 -> 0x58. Reload 0x96, then s=110, amt=2 -> 0xE5. Any shift mode with amt=0 -> q unchanged.
- Rotates: load 0x96, then s=100, amt=4 -> 0x69. Load 0x81, then s=101, amt=1 -> 0x03. With en=0 during a rotate -> q holds.
- Serialise: s=111, din=0xA5, en=1 -> sout_r sequence 1,0,1,0,0,1,0,1 over 8 cycles. busy is high for exactly 8 cycles and done is high in the 8th only.
- Pause and back-to-back:
  - en=0 for 2 cycles after the 3rd bit -> stream resumes with no lost or duplicated bit; busy lasts 10 cycles.
  - s=111, din=0x3C in the done cycle -> 16 contiguous bits (0xA5 then 0x3C, LSB first); busy never drops; done pulses twice.

Source files
------------

// File: rtl/usr_pkg.sv
// Package for the universal shift register: the eight mode-select codes
// applied on s.
package usr_pkg;

  localparam logic [2:0] USR_HOLD = 3'b000;  // keep q
  localparam logic [2:0] USR_SHR  = 3'b001;  // logical shift right, fill with sin
  localparam logic [2:0] USR_SHL  = 3'b010;  // logical shift left, fill with sin
  localparam logic [2:0] USR_LOAD = 3'b011;  // parallel load from din
  localparam logic [2:0] USR_ROR  = 3'b100;  // rotate right
  localparam logic [2:0] USR_ROL  = 3'b101;  // rotate left
  localparam logic [2:0] USR_ASR  = 3'b110;  // arithmetic shift right
  localparam logic [2:0] USR_SER  = 3'b111;  // serialiser start

endpackage : usr_pkg

// File: rtl/usr_barrel.sv
// Combinational WIDTH-bit barrel shifter built from log2(WIDTH) mux stages.
// Stage k moves the data by 2**k positions when amt[k] is set.
//   data   : input word
//   amt    : shift/rotate distance
//   dir    : 0 = right, 1 = left
//   rotate : 1 = bits shifted out re-enter at the other end
//   arith  : 1 = vacated bits take data[WIDTH-1] (fill is ignored)
//   fill   : bit replicated into vacated positions for logical shifts
//   result : shifted word
module usr_barrel #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  logic             dir,
  input  logic             rotate,
  input  logic             arith,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] fill_vec;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    stage    = data;
    // The sign bit is taken from the original word, so every stage fills alike.
    fill_vec = {WIDTH{arith ? data[WIDTH-1] : fill}};
    for (int k = 0; k < AW; k++) begin
      if (amt[k]) begin
        if (dir) begin
          stage = rotate ? ((stage << (1 << k)) | (stage    >> (WIDTH - (1 << k))))
                         : ((stage << (1 << k)) | (fill_vec >> (WIDTH - (1 << k))));
        end else begin
          stage = rotate ? ((stage >> (1 << k)) | (stage    << (WIDTH - (1 << k))))
                         : ((stage >> (1 << k)) | (fill_vec << (WIDTH - (1 << k))));
        end
      end
    end
    result = stage;
  end

endmodule : usr_barrel

// File: rtl/univ_shift_reg_param.sv
// Parametrised universal shift register with barrel shifts, rotates,
// arithmetic shift right and a self-timed LSB-first serialiser.
//   clk, rst       : rising-edge clock, synchronous active-low reset
//   en             : operation enable (0 = hold / pause the serialiser)
//   s, amt         : mode select and shift/rotate amount
//   din, sin       : parallel load data, serial fill bit
//   q              : register contents
//   sout_r, sout_l : q[0] and q[WIDTH-1]
//   busy, done     : serialiser active, final serial bit on sout_r
module univ_shift_reg_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       s,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] CNT_LAST = AW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] bar_result;

  usr_barrel #(.WIDTH(WIDTH), .AW(AW)) u_barrel (
    .data   (q_q),
    .amt    (amt),
    .dir    ((s == USR_SHL) || (s == USR_ROL)),
    .rotate ((s == USR_ROR) || (s == USR_ROL)),
    .arith  (s == USR_ASR),
    .fill   (sin),
    .result (bar_result)
  );

  always_comb begin
    q_d    = q_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (en) begin
      if (busy_q) begin
        if (cnt_q != '0) begin
          q_d   = {sin, q_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
        end else if (s == USR_SER) begin
          // Back-to-back start in the done cycle keeps the stream gapless.
          q_d   = din;
          cnt_d = CNT_LAST;
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        case (s)
          USR_SHR, USR_SHL, USR_ROR, USR_ROL, USR_ASR: q_d = bar_result;
          USR_LOAD: q_d = din;
          USR_SER: begin
            q_d    = din;
            busy_d = 1'b1;
            cnt_d  = CNT_LAST;
          end
          default: q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst) begin
      q_q    <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == '0);

endmodule : univ_shift_reg_param

// File: tb/tb_univ_shift_reg_param.sv
// Directed self-checking bench for univ_shift_reg_param at WIDTH=8.
module tb_univ_shift_reg_param;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst, en, sin;
  logic [2:0]       s;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             sout_r, sout_l, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  univ_shift_reg_param #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .s      (s),
    .amt    (amt),
    .din    (din),
    .sin    (sin),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Advance one edge and let outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] mode, input logic [AW-1:0] a,
                    input logic [WIDTH-1:0] d, input logic si);
    s = mode; amt = a; din = d; sin = si; en = 1'b1;
    step();
  endtask

  task automatic cmp_q(input string name, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (q !== exp) begin
      n_bad++;
      $display("FAIL %s: q got %h expected %h", name, q, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; s = 3'b011; din = 8'hFF; amt = '0; sin = 1'b0;
    step();
    step();
    cmp_q("reset_q", 8'h00);
    n_cmp++;
    if ({busy, done, sout_r, sout_l} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: busy/done/sout_r/sout_l got %b expected 0000",
               {busy, done, sout_r, sout_l});
    end
    rst = 1'b1;
    op(3'b111, '0, 8'hA5, 1'b0);
    s = 3'b000;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_midser_busy_before: busy got %b expected 1", busy);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || q !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_abort: busy=%b q=%h expected busy=0 q=00", busy, q);
    end
    rst = 1'b1;
  endtask

  task automatic test_shifts();
    op(3'b011, '0, 8'h96, 1'b0);
    cmp_q("load_96", 8'h96);
    n_cmp++;
    if (sout_l !== 1'b1 || sout_r !== 1'b0) begin
      n_bad++;
      $display("FAIL sout_taps: sout_l=%b sout_r=%b expected 1 0", sout_l, sout_r);
    end
    op(3'b001, 3'd3, 8'h00, 1'b1);
    cmp_q("shr3_sin1", 8'hF2);
    op(3'b011, '0, 8'h96, 1'b0);
    op(3'b010, 3'd2, 8'h00, 1'b0);
    cmp_q("shl2_sin0", 8'h58);
    op(3'b011, '0, 8'h96, 1'b0);
    op(3'b110, 3'd2, 8'h00, 1'b0);
    cmp_q("asr2", 8'hE5);
    op(3'b001, 3'd0, 8'h00, 1'b1);
    cmp_q("shr_amt0", 8'hE5);
    op(3'b110, 3'd0, 8'h00, 1'b0);
    cmp_q("asr_amt0", 8'hE5);
    op(3'b011, '0, 8'h96, 1'b0);
    op(3'b010, 3'd7, 8'h00, 1'b1);
    cmp_q("shl7_sin1", 8'h7F);
  endtask

  task automatic test_rotates();
    op(3'b011, '0, 8'h96, 1'b0);
    op(3'b100, 3'd4, 8'h00, 1'b0);
    cmp_q("ror4", 8'h69);
    op(3'b011, '0, 8'h81, 1'b0);
    op(3'b101, 3'd1, 8'h00, 1'b0);
    cmp_q("rol1", 8'h03);
    s = 3'b100; amt = 3'd1; en = 1'b0;
    step();
    cmp_q("ror_en0_hold", 8'h03);
    op(3'b100, 3'd1, 8'h00, 1'b0);
    cmp_q("ror1", 8'h81);
    op(3'b101, 3'd0, 8'h00, 1'b0);
    cmp_q("rol_amt0", 8'h81);
  endtask

  task automatic test_serialise();
    logic [WIDTH-1:0] word;
    word = 8'hA5;
    op(3'b111, '0, word, 1'b0);
    s = 3'b000; din = 8'h00;
    for (int c = 0; c < WIDTH; c++) begin
      n_cmp++;
      if (sout_r !== word[c] || busy !== 1'b1 || done !== (c == WIDTH - 1)) begin
        n_bad++;
        $display("FAIL ser_cycle%0d: sout_r=%b busy=%b done=%b expected %b 1 %b",
                 c, sout_r, busy, done, word[c], (c == WIDTH - 1));
      end
      step();
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL ser_end: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_pause();
    logic [WIDTH-1:0] word;
    int idx [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
    word = 8'hA5;
    op(3'b111, '0, word, 1'b0);
    s = 3'b000;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (sout_r !== word[idx[c]] || busy !== 1'b1 || done !== (c == 9)) begin
        n_bad++;
        $display("FAIL pause_cycle%0d: sout_r=%b busy=%b done=%b expected %b 1 %b",
                 c, sout_r, busy, done, word[idx[c]], (c == 9));
      end
      en = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      step();
    end
    en = 1'b1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_end: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w0, w1, word;
    int pulses;
    w0 = 8'hA5; w1 = 8'h3C; pulses = 0;
    op(3'b111, '0, w0, 1'b1);
    s = 3'b000; din = 8'h00;
    for (int c = 0; c < 2 * WIDTH; c++) begin
      word = (c < WIDTH) ? w0 : w1;
      if (done === 1'b1) pulses++;
      n_cmp++;
      if (sout_r !== word[c % WIDTH] || busy !== 1'b1 ||
          done !== (c == WIDTH - 1 || c == 2 * WIDTH - 1)) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: sout_r=%b busy=%b done=%b expected %b 1 %b",
                 c, sout_r, busy, done, word[c % WIDTH],
                 (c == WIDTH - 1 || c == 2 * WIDTH - 1));
      end
      if (c == WIDTH - 1) begin
        s = 3'b111; din = w1;
      end else begin
        s = 3'b000; din = 8'h00;
      end
      step();
    end
    n_cmp++;
    if (pulses != 2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: done pulses=%0d busy=%b expected 2 0", pulses, busy);
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_rotates();
    test_serialise();
    test_pause();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_univ_shift_reg_param
